// File: rtl/button_conditioner.sv
// Four-channel push-button front end: 2-flop sync, debounce, rising-edge detect, fixed-priority one-hot pulse.
// Optional post-pulse lockout window enabled by defining BTN_LOCKOUT_EN; otherwise busy_o is tied low.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LOCKOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw_i,
    output logic       pulse_hit_o,
    output logic       pulse_stand_o,
    output logic       pulse_double_o,
    output logic       pulse_start_o,
    output logic [3:0] btn_level_o,
    output logic       busy_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [3:0]          r_stable;
    logic [3:0]          r_stable_prev;
    logic [3:0][CW-1:0]  r_cnt;
    logic [3:0]          r_pulse;
    logic [3:0]          w_rise;
    logic [3:0]          w_grant;
    logic                w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw_i;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where sync matches the stable level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_prev <= '0;
        end else begin
            r_stable_prev <= r_stable;
        end
    end

    // Edges seen while locked out are discarded, never deferred.
    assign w_rise = r_stable & ~r_stable_prev & {4{~w_busy}};

    // Priority: start[3] > stand[1] > double[2] > hit[0].
    always_comb begin
        w_grant = 4'b0000;
        if (w_rise[3]) begin
            w_grant = 4'b1000;
        end else if (w_rise[1]) begin
            w_grant = 4'b0010;
        end else if (w_rise[2]) begin
            w_grant = 4'b0100;
        end else if (w_rise[0]) begin
            w_grant = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_grant;
        end
    end

`ifdef BTN_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    logic [LW-1:0] r_lock_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
        end else if (|w_grant) begin
            r_lock_cnt <= LW'(LOCKOUT_CYCLES);
        end else if (r_lock_cnt != '0) begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
        end
    end

    assign w_busy = (r_lock_cnt != '0);
`else
    logic w_unused_lockout;
    assign w_unused_lockout = |LOCKOUT_CYCLES;
    assign w_busy = 1'b0;
`endif

    assign pulse_hit_o    = r_pulse[0];
    assign pulse_stand_o  = r_pulse[1];
    assign pulse_double_o = r_pulse[2];
    assign pulse_start_o  = r_pulse[3];
    assign btn_level_o    = r_stable;
    assign busy_o         = w_busy;

endmodule
